// File: rtl/mem_bridge_pkg.sv
// Shared encodings for the CPU-to-LPDDR2 request bridge: controller idle code,
// bridge state encoding and the byte-lane count helper.
package mem_bridge_pkg;

  localparam logic [3:0] MEM_IDLE = 4'd1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_RD_REQ   = 3'd1;
  localparam state_t S_RD_WAIT  = 3'd2;
  localparam state_t S_RMW_REQ  = 3'd3;
  localparam state_t S_RMW_WAIT = 3'd4;
  localparam state_t S_WR_REQ   = 3'd5;
  localparam state_t S_WR_WAIT  = 3'd6;

  function automatic int unsigned lane_count(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge: enabled lanes come from the new word,
// the remaining lanes keep the old word.
module byte_lane_merge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]              old_word,
  input  logic [DATA_W-1:0]              new_word,
  input  logic [lane_count(DATA_W)-1:0]  be,
  output logic [DATA_W-1:0]              merged_c
);

  always_comb begin
    merged_c = old_word;
    for (int i = 0; i < int'(lane_count(DATA_W)); i++) begin
      if (be[i]) merged_c[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_req_bridge.sv
// CPU load/store front end for the lpddr2_memory controller: stalls the core,
// issues read/write requests, and turns partial stores into read-modify-write.
module mem_req_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W    = 27,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                           iCLK,
  input  logic                           iRST_n,
  input  logic                           cpu_re,
  input  logic                           cpu_we,
  input  logic [31:0]                    cpu_addr,
  input  logic [DATA_W-1:0]              cpu_wdata,
  input  logic [lane_count(DATA_W)-1:0]  cpu_be,
  output logic [DATA_W-1:0]              cpu_rdata,
  output logic                           cpu_done,
  output logic                           cpu_err,
  output logic                           cpu_stall,
  output logic                           read_req,
  output logic                           write_req,
  output logic [ADDR_W-1:0]              addr,
  output logic [DATA_W-1:0]              inData,
  input  logic [DATA_W-1:0]              outData,
  input  logic [3:0]                     mem_state
);

  // Fires one count early so the phase ends after exactly 2^W-1 cycles.
  localparam logic [TIMEOUT_W-1:0] WD_FIRE = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t                state_q, state_d;
  logic [TIMEOUT_W-1:0]  wd_q, wd_d;
  logic                  read_d, write_d, done_d, err_d;
  logic [ADDR_W-1:0]     addr_d;
  logic [DATA_W-1:0]     data_d, rdata_d, merged_c;
  logic                  mem_idle_c;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};
  assign mem_idle_c       = (mem_state == MEM_IDLE);
  assign cpu_stall        = (cpu_re | cpu_we) & ~cpu_done;

  byte_lane_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word (outData),
    .new_word (cpu_wdata),
    .be       (cpu_be),
    .merged_c (merged_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    read_d  = read_req;
    write_d = write_req;
    addr_d  = addr;
    data_d  = inData;
    rdata_d = cpu_rdata;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((cpu_re | cpu_we) && mem_idle_c && !cpu_done) begin
          addr_d = cpu_addr[ADDR_W+1:2];
          data_d = cpu_wdata;
          if (!cpu_we) begin
            state_d = S_RD_REQ;
            read_d  = 1'b1;
          end else if (&cpu_be) begin
            state_d = S_WR_REQ;
            write_d = 1'b1;
          end else if (cpu_be == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RMW_REQ;
            read_d  = 1'b1;
          end
        end
      end
      S_RD_REQ, S_RMW_REQ: begin
        if (!mem_idle_c) begin
          read_d  = 1'b0;
          state_d = (state_q == S_RD_REQ) ? S_RD_WAIT : S_RMW_WAIT;
        end
      end
      S_WR_REQ: begin
        if (!mem_idle_c) begin
          write_d = 1'b0;
          state_d = S_WR_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (mem_idle_c) begin
          rdata_d = outData;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RMW_WAIT: begin
        if (mem_idle_c) begin
          data_d  = merged_c;
          write_d = 1'b1;
          state_d = S_WR_REQ;
        end
      end
      S_WR_WAIT: begin
        if (mem_idle_c) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase

    // Watchdog abandons a phase that has not progressed.
    if (state_q != S_IDLE && state_d == state_q && wd_q == WD_FIRE) begin
      state_d = S_IDLE;
      read_d  = 1'b0;
      write_d = 1'b0;
      done_d  = 1'b1;
      err_d   = 1'b1;
    end

    wd_d = (state_d != state_q || state_q == S_IDLE) ? '0 : wd_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= S_IDLE;
      wd_q      <= '0;
      read_req  <= 1'b0;
      write_req <= 1'b0;
      addr      <= '0;
      inData    <= '0;
      cpu_rdata <= '0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      read_req  <= read_d;
      write_req <= write_d;
      addr      <= addr_d;
      inData    <= data_d;
      cpu_rdata <= rdata_d;
      cpu_done  <= done_d;
      cpu_err   <= err_d;
    end
  end

endmodule

// File: doc/mem_req_bridge.md
# mem_req_bridge

CPU-side front end for the `lpddr2_memory` controller. It accepts single-word load/store requests from the MIPS core, stalls the core while a request is in flight, and converts byte addresses to word addresses. It drives the controller's `read_req`/`write_req`/`addr`/`inData`, detects completion from the controller's `c_state` output, and turns partial-word stores into read-modify-write sequences.

## Interface
- `ADDR_W`, 27: controller word-address width.
- `DATA_W`, 32: data width; byte lanes = DATA_W/8.
- `TIMEOUT_W`, 16: watchdog counter width; timeout at 2^TIMEOUT_W−1 cycles per memory phase.

- `iCLK`  in  1  sole clock.
- `iRST_n`  in  1  reset, asynchronous, active-low.
- `cpu_re`  in  1  load request, level, held until `cpu_done`.
- `cpu_we`  in  1  store request, level, held until `cpu_done`. If both `cpu_re` and `cpu_we` are set, the request is a store.
- `cpu_addr`  in  32  byte address. Bits [1:0] are ignored.
- `cpu_wdata`  in  DATA_W  store data.
- `cpu_be`  in  DATA_W/8  store byte enables.
- `cpu_rdata`  out  DATA_W  load result, registered. Valid from the `cpu_done` cycle until the next load completes.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  one-cycle pulse, coincident with `cpu_done`, when the watchdog fires.
- `cpu_stall`  out  1  `(cpu_re|cpu_we) & !cpu_done`, combinational.
- `read_req`, `write_req`  out  1  controller requests, registered.
- `addr`  out  ADDR_W  equals `cpu_addr[ADDR_W+1:2]`, registered.
- `inData`  out  DATA_W  write word, registered.
- `outData`  in  DATA_W  controller read data.
- `mem_state`  in  4  controller `c_state`. Value 1 means the controller is idle.

## Operation
- The state machine has these states:
  - `IDLE`
  - `RD_REQ`, `RD_WAIT`
  - `RMW_REQ`, `RMW_WAIT`
  - `WR_REQ`, `WR_WAIT`
- **IDLE.** A request is accepted when `(cpu_re|cpu_we)` is set, `mem_state==1`, and `cpu_done` was not pulsed in the previous cycle. On acceptance, `addr` and `inData` are latched.
  - Load → `RD_REQ`.
  - Store with `be==all ones` → `WR_REQ`.
  - Store with `be==0` → `cpu_done` next cycle, no memory access.
  - Any other store → `RMW_REQ`.
- **Request phases (`*_REQ`).** The request line (read for `RD`/`RMW`, write for `WR`) is held at 1 until `mem_state!=1` is sampled. It is then cleared and the machine moves to `*_WAIT`.
- **Wait phases (`*_WAIT`).** The machine waits for `mem_state==1`.
  - `RD_WAIT`: `cpu_rdata<=outData`, pulse `cpu_done`, go to `IDLE`.
  - `RMW_WAIT`: merge into `inData`, taking `cpu_wdata` lanes where `be=1` and `outData` lanes elsewhere, then go to `WR_REQ`.
  - `WR_WAIT`: pulse `cpu_done`, go to `IDLE`.
- `read_req` and `write_req` are never high together.
- `addr` and `inData` are stable from the request phase until the wait phase ends. The only exception is the merge update, which happens before `WR_REQ`.
- **Watchdog.** The counter clears on every state change and increments otherwise. At terminal count the machine clears both requests, pulses `cpu_done` and `cpu_err`, and returns to `IDLE`. `cpu_rdata` is not updated. The next request is still gated on `mem_state==1`.
- **Reset.** Asynchronous, including mid-transaction. All outputs and registers go to 0 and the state returns to `IDLE`.

## Timing
- Load: accept at edge N; `read_req` is high from N+1. Controller transaction time is T, measured from its leaving idle back to idle. Total latency is roughly T+3 cycles.
- Full store: same as a load, with `write_req` instead of `read_req`.
- Partial store: read transaction plus write transaction, plus 2 cycles.
- After the controller leaves idle, the request line drops within 1 cycle. The controller ignores requests outside its idle state, so this holdover is harmless.
- The cycle after `cpu_done`, the CPU must present the next request or drop its request lines. The bridge never re-accepts in that cycle.

## Structure
- `mem_bridge_pkg` holds:
  - the state enum;
  - `localparam MEM_IDLE = 4'd1`;
  - lane count derived from `DATA_W`.
- One sub-module, `byte_lane_merge`: combinational. Inputs are old word, new word and enables; output is the merged word.

## Test plan
- **Load.** Model controller idle→READ→WAIT_READ(3 cycles)→idle with `outData=32'hDEADBEEF`; `cpu_addr=32'h0000_0104` → `addr=27'h41`. `cpu_rdata=32'hDEADBEEF` with one `cpu_done` pulse. `read_req` is high for exactly 2 cycles.
- **Full store.** `cpu_be=4'hF`, `cpu_wdata=32'h12345678` → `write_req` only, `inData=32'h12345678` held until done, `read_req` never set.
- **Partial store (RMW).** `cpu_be=4'b0101`, memory word `32'hAABBCCDD`, `cpu_wdata=32'h11223344` → one read, then a write with `inData=32'hAA22CC44`.
- **Zero-enable store.** `cpu_be=0` → `cpu_done` 2 cycles after the request, no `read_req`/`write_req`.
- **Controller not ready.** `mem_state=0` (INIT) for 20 cycles with `cpu_re` set → `cpu_stall` high, no request issued. Issue occurs within 1 cycle of `mem_state` becoming 1.
- **Timeout and reset.** With `TIMEOUT_W=4` and the controller stuck non-idle → `cpu_err` and `cpu_done` together after 15 cycles. Asserting `iRST_n=0` mid-RMW clears `read_req`, `write_req` and `cpu_done` immediately, without waiting for a clock edge.
